// File: rtl/press_classifier_if.sv
// rtl/press_classifier_if.sv - button level in, gesture events out
// Purpose: bundles the debounced button level and the gesture event outputs.
// Signals:
//   button_in    debounced button level, 1 = pressed
//   pressed      1-cycle pulse on each 0->1 edge
//   released     1-cycle pulse on each 1->0 edge
//   short_press  1-cycle pulse, single press with no second press in the gap
//   double_press 1-cycle pulse, second press began within the gap
//   long_press   1-cycle pulse, first press held long enough
//   repeat_press 1-cycle pulse, periodic while long-held
//   long_held    level, high while the long hold is in progress
// Modports: master drives button_in and observes events; slave is the classifier.
interface press_classifier_if;
  logic button_in;
  logic pressed;
  logic released;
  logic short_press;
  logic double_press;
  logic long_press;
  logic repeat_press;
  logic long_held;

  modport master (
    output button_in,
    input  pressed, released, short_press, double_press,
    input  long_press, repeat_press, long_held
  );

  modport slave (
    input  button_in,
    output pressed, released, short_press, double_press,
    output long_press, repeat_press, long_held
  );
endinterface

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - turns a debounced button level into gesture pulses
// Purpose: edge pulses plus short/double/long/repeat gesture detection, all
// outputs registered.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    press_classifier_if.slave (button_in in, event pulses/levels out)
module press_classifier #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int GAP_CYCLES    = 25000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic               clk,
  input  logic               reset,
  press_classifier_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HELD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST =
    (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             rise, fall;

  logic short_d, double_d, long_d, repeat_d;

  logic pressed_q, released_q, short_q, double_q, long_q, repeat_q, held_q;

  assign rise = bus.button_in & ~btn_q;
  assign fall = ~bus.button_in & btn_q;

  // Next-state and gesture decode. The counter restarts on every state change
  // so each state measures time since it was entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_d = WAIT_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_GAP: begin
        // A rise on the expiry edge still counts as a double press.
        if (rise) begin
          double_d = 1'b1;
          state_d  = PRESS2;
          cnt_d    = '0;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      LONG_HELD: begin
        // Release beats a coincident repeat expiry.
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (REPEAT_CYCLES != 0) begin
          if (cnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // btn_q resets to 1 so a button held through reset is not seen as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      btn_q      <= 1'b1;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      short_q    <= 1'b0;
      double_q   <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_q      <= bus.button_in;
      pressed_q  <= rise;
      released_q <= fall;
      short_q    <= short_d;
      double_q   <= double_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
      held_q     <= (state_d == LONG_HELD);
    end
  end

  assign bus.pressed      = pressed_q;
  assign bus.released     = released_q;
  assign bus.short_press  = short_q;
  assign bus.double_press = double_q;
  assign bus.long_press   = long_q;
  assign bus.repeat_press = repeat_q;
  assign bus.long_held    = held_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - scoreboard bench for press_classifier
module tb_press_classifier;

  localparam int L = 8;
  localparam int G = 4;
  localparam int R = 3;

  localparam logic [5:0] EV_PR = 6'b000001;
  localparam logic [5:0] EV_RL = 6'b000010;
  localparam logic [5:0] EV_SH = 6'b000100;
  localparam logic [5:0] EV_DB = 6'b001000;
  localparam logic [5:0] EV_LG = 6'b010000;
  localparam logic [5:0] EV_RP = 6'b100000;

  typedef struct {
    int         e;
    logic [5:0] v;
  } ev_t;

  typedef struct {
    int a;
    int b;
  } iv_t;

  logic clk = 1'b0;
  logic reset;
  logic button;
  int   edge_n = 0;
  bit   run = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Gesture model state, tracked per button segment rather than per cycle.
  bit prev;
  bit gap_open;
  bit dbl;

  ev_t evq[2][$];
  iv_t ivq[2][$];

  press_classifier_if if0 ();
  press_classifier_if if1 ();

  assign if0.button_in = button;
  assign if1.button_in = button;

  press_classifier #(
    .LONG_CYCLES(L), .GAP_CYCLES(G), .REPEAT_CYCLES(R), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(if0)
  );

  press_classifier #(
    .LONG_CYCLES(L), .GAP_CYCLES(G), .REPEAT_CYCLES(0), .CNT_W(4)
  ) dut_norep (
    .clk(clk), .reset(reset), .bus(if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [5:0] vec(int d);
    if (d == 0)
      return {if0.repeat_press, if0.long_press, if0.double_press,
              if0.short_press, if0.released, if0.pressed};
    return {if1.repeat_press, if1.long_press, if1.double_press,
            if1.short_press, if1.released, if1.pressed};
  endfunction

  function automatic logic held(int d);
    return (d == 0) ? if0.long_held : if1.long_held;
  endfunction

  function automatic int rep_of(int d);
    return (d == 0) ? R : 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void push_ev(int d, int e, logic [5:0] v);
    ev_t t;
    t.e = e;
    t.v = v;
    evq[d].push_back(t);
  endfunction

  function automatic void push_iv(int d, int a, int b);
    iv_t t;
    t.a = a;
    t.b = b;
    ivq[d].push_back(t);
  endfunction

  // Drive one constant-level segment of n cycles and enqueue the gestures it
  // implies: a press of length n either becomes long (held past L) or opens
  // a gap; a release of length n either closes the gap with a double press
  // (next press within G) or lets it expire as a short press.
  task automatic seg(bit lvl, int n);
    int s;
    s = edge_n + 1;
    if (lvl && !prev) begin
      for (int d = 0; d < 2; d++) begin
        push_ev(d, s, dbl ? (EV_PR | EV_DB) : EV_PR);
        if (!dbl && n >= L + 1) begin
          push_ev(d, s + L, EV_LG);
          push_iv(d, s + L, s + n - 1);
          if (rep_of(d) != 0)
            for (int t = s + L + rep_of(d); t < s + n; t += rep_of(d))
              push_ev(d, t, EV_RP);
        end
      end
      gap_open = !dbl && (n <= L);
      dbl = 1'b0;
    end else if (!lvl && prev) begin
      for (int d = 0; d < 2; d++) begin
        push_ev(d, s, EV_RL);
        if (gap_open && n > G) push_ev(d, s + G, EV_SH);
      end
      dbl = gap_open && (n <= G);
      gap_open = 1'b0;
    end
    prev = lvl;
    button = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " dut0 outputs"}, {25'b0, if0.long_held, vec(0)}, 32'h0);
    chk({tag, " dut1 outputs"}, {25'b0, if1.long_held, vec(1)}, 32'h0);
  endtask

  // Reset discards anything the model predicted past the current edge.
  task automatic do_reset(bit lvl, int n);
    #2;
    reset = 1'b1;
    button = lvl;
    for (int d = 0; d < 2; d++) begin
      while (evq[d].size() > 0 && evq[d][evq[d].size()-1].e > edge_n)
        void'(evq[d].pop_back());
      while (ivq[d].size() > 0 && ivq[d][ivq[d].size()-1].a > edge_n)
        void'(ivq[d].pop_back());
      if (ivq[d].size() > 0 && ivq[d][ivq[d].size()-1].b > edge_n)
        ivq[d][ivq[d].size()-1].b = edge_n;
    end
    #1;
    chk_zero("mid reset");
    gap_open = 1'b0;
    dbl = 1'b0;
    prev = 1'b1;
    repeat (n) @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic mon(int d);
    int cur;
    logic [5:0] act;
    logic exp_lh;
    cur = edge_n;
    act = vec(d);
    while (evq[d].size() > 0 && evq[d][0].e < cur) begin
      chk($sformatf("dut%0d missed edge %0d", d, evq[d][0].e), 32'h0,
          {26'b0, evq[d][0].v});
      void'(evq[d].pop_front());
    end
    if (evq[d].size() > 0 && evq[d][0].e == cur) begin
      chk($sformatf("dut%0d events edge %0d", d, cur), {26'b0, act},
          {26'b0, evq[d][0].v});
      void'(evq[d].pop_front());
    end else if (act != 6'b0) begin
      chk($sformatf("dut%0d unexpected edge %0d", d, cur), {26'b0, act}, 32'h0);
    end
    while (ivq[d].size() > 0 && ivq[d][0].b < cur) void'(ivq[d].pop_front());
    exp_lh = (ivq[d].size() > 0) && (ivq[d][0].a <= cur);
    chk($sformatf("dut%0d long_held edge %0d", d, cur), {31'b0, held(d)},
        {31'b0, exp_lh});
  endtask

  always @(negedge clk) begin
    if (run && !reset) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    reset = 1'b1;
    button = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset state");
    prev = 1'b1;
    gap_open = 1'b0;
    dbl = 1'b0;
    run = 1'b1;
    #2;
    reset = 1'b0;

    // Single short press.
    seg(0, 3);
    seg(1, 3);
    seg(0, 10);
    // Double press.
    seg(1, 2);
    seg(0, 2);
    seg(1, 2);
    seg(0, 10);
    // Long hold with repeats.
    seg(1, 16);
    seg(0, 10);
    // Second rise exactly on the gap-expiry edge, then one cycle later.
    seg(1, 2);
    seg(0, 4);
    seg(1, 2);
    seg(0, 6);
    seg(1, 2);
    seg(0, 5);
    seg(1, 2);
    seg(0, 10);
    // Button held through reset.
    do_reset(1'b1, 3);
    seg(1, 5);
    seg(0, 10);
    // Reset in the middle of a first press.
    seg(1, 6);
    do_reset(1'b0, 2);
    seg(0, 12);
    // Longer hold.
    seg(1, 20);
    seg(0, 8);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 7) == 0)
        do_reset(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      seg(1'b1, int'($urandom_range(1, 14)));
      seg(1'b0, int'($urandom_range(1, 7)));
    end
    seg(1, 2);
    seg(0, 12);
    repeat (3) @(negedge clk);
    run = 1'b0;
    chk("dut0 leftover events", evq[0].size(), 32'h0);
    chk("dut1 leftover events", evq[1].size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
Name: press_classifier

Overview:
Consumes the debounced, clock-synchronous button level from the debouncer stage and turns it into single-cycle gesture events: press/release edges, short press, double press, long press and auto-repeat while held. Sits directly downstream of the debouncer and upstream of the application logic (LED/mode control). All outputs are registered, one clock domain (100 MHz Cu clock).

Parameters:
LONG_CYCLES, 50000000, cycles a first press must be held before long_press fires (500 ms at 100 MHz); must be >= 2
GAP_CYCLES, 25000000, max cycles between first release and second press for a double press (250 ms); must be >= 2
REPEAT_CYCLES, 10000000, cycles between repeat_press pulses while long-held (100 ms); 0 disables repeat
CNT_W, 26, counter width; must hold max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high reset
button_in  input  1  debounced button level, 1 = pressed, already synchronous to clk
pressed  output  1  one-cycle pulse on each 0->1 edge of button_in
released  output  1  one-cycle pulse on each 1->0 edge of button_in
short_press  output  1  one-cycle pulse: single press+release, no second press within gap
double_press  output  1  one-cycle pulse: second press began within gap
long_press  output  1  one-cycle pulse: first press held LONG_CYCLES
repeat_press  output  1  one-cycle pulse every REPEAT_CYCLES while long-held
long_held  output  1  level, high while in LONG_HELD state

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, counter 0, btn_q (previous sample) = 1. Button held through reset therefore yields a released pulse but no pressed pulse and no gesture.
- rise = button_in & ~btn_q; fall = ~button_in & btn_q; evaluated each posedge. Edge sampled at edge k -> pressed/released high for exactly the cycle after edge k (1-cycle latency). Edge pulses are independent of state.
- Gesture FSM, states IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD; transitions occur on the same edge that samples the triggering input; counter cleared on every state change:
  - IDLE: rise -> PRESS1. fall ignored.
  - PRESS1: button_in=1: counter+1; when counter == LONG_CYCLES-1 at an edge -> long_press pulse, -> LONG_HELD. Net: rise sampled at edge k -> long_press after edge k+LONG_CYCLES. fall -> WAIT_GAP.
  - WAIT_GAP: rise -> double_press pulse, -> PRESS2. Else counter+1; when counter == GAP_CYCLES-1 -> short_press pulse, -> IDLE. Rise on the same edge as gap expiry: rise wins (double_press, no short_press).
  - PRESS2: waits for fall -> IDLE. No long/repeat from a second press regardless of duration.
  - LONG_HELD: long_held=1. If REPEAT_CYCLES != 0: counter+1; when counter == REPEAT_CYCLES-1 -> repeat_press pulse, counter to 0 (first repeat REPEAT_CYCLES cycles after long_press). fall -> IDLE (no short_press); fall on same edge as repeat expiry: fall wins, no repeat pulse.
- At most one gesture pulse (short/double/long/repeat) per cycle. Counter never wraps: compared with == and cleared on every exit; CNT_W sizing is the integrator's responsibility.
- long_held deasserts the cycle after fall is sampled.
- Reset asserted mid-gesture: immediate return to reset values, no pending gesture emitted after release.

Test Plan:
(Params LONG_CYCLES=8, GAP_CYCLES=4, REPEAT_CYCLES=3.)
- Reset with button_in=0, press 3 cycles, release, idle 10 -> pressed 1 cycle after rise, released 1 cycle after fall, short_press exactly 4 cycles after fall sample, no other events.
- Press 2, release 2, press 2, release -> two pressed, two released, one double_press on second rise+1, no short_press.
- Press held 16 cycles -> long_press 8 cycles after rise, long_held high from then until 1 cycle after fall, repeat_press at +3 and +6 after long_press, no short_press on release.
- Second rise on exact gap-expiry edge (release, then rise 4 cycles later) -> double_press only; one cycle later -> short_press then fresh PRESS1.
- Hold button_in=1 through reset and release reset, then release button -> released pulse, no pressed, no gesture; reset asserted mid-PRESS1 -> all outputs 0 immediately, no long_press.
- REPEAT_CYCLES=0 build, hold 20 cycles -> one long_press, zero repeat_press.
